ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_pkg.sv | 39 +++
 rtl/ps2_key_decoder_line_filter.sv | 69 ++++++
 rtl/ps2_key_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// ps2_key_decoder_pkg
//   Shared definitions for the PS/2 keyboard decoder:
//   - rx_state_t : receive FSM state encoding
//   - CODE_EXT / CODE_BREAK : scan-code prefix bytes
//   - CODE_UP / CODE_DOWN / CODE_LEFT / CODE_RIGHT : the four tracked keys
//   - key_mask() : maps a scan code to its one-hot bit in keys_keyboard
package ps2_key_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;

  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;

  // One-hot position of a tracked key in keys_keyboard; zero for any
  // code that does not correspond to one of the four arrow keys.
  function automatic logic [3:0] key_mask(input logic [7:0] code);
    logic [3:0] mask;
    mask = 4'b0000;
    case (code)
      CODE_UP:    mask = 4'b0001;
      CODE_DOWN:  mask = 4'b0010;
      CODE_LEFT:  mask = 4'b0100;
      CODE_RIGHT: mask = 4'b1000;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_line_filter.sv
// ps2_line_filter
//   Brings the raw PS/2 clock and data pins into the system clock domain
//   and debounces the clock line.
//
//   Ports:
//     clock     in   system clock
//     reset_n   in   asynchronous active-low reset
//     ps2_clk   in   raw PS/2 clock pin (asynchronous)
//     ps2_data  in   raw PS/2 data pin (asynchronous)
//     clk_fall  out  one-cycle strobe: filtered ps2_clk has gone 1 -> 0
//     data_bit  out  synchronized ps2_data captured when clk_fall fires;
//                    valid in the same cycle as clk_fall
//
//   The filtered clock level only moves after FILTER_LEN consecutive
//   synchronized samples disagree with it, so any pulse shorter than
//   FILTER_LEN cycles never reaches the receiver.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_fall,
  output logic data_bit
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_level;
  logic [CW-1:0] run_cnt;

  // Two-flop synchronizers; both lines idle high on the bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // run_cnt counts how many samples in a row have disagreed with the
  // accepted level; any agreeing sample restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_level <= 1'b1;
      run_cnt   <= '0;
      clk_fall  <= 1'b0;
      data_bit  <= 1'b1;
    end else begin
      clk_fall <= 1'b0;
      if (clk_sync[1] == clk_level) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        clk_level <= clk_sync[1];
        run_cnt   <= '0;
        clk_fall  <= ~clk_sync[1];
        data_bit  <= data_sync[1];
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd
//   parity, stop) and tracks the held state of the four arrow keys.
//
//   Ports:
//     clock          in   system clock (50 MHz)
//     reset_n        in   asynchronous active-low reset
//     ps2_clk        in   raw PS/2 clock pin
//     ps2_data       in   raw PS/2 data pin
//     keys_keyboard  out  held keys: [0] up, [1] down, [2] left, [3] right
//     scan_code      out  last byte received without error
//     scan_valid     out  one-cycle strobe when scan_code is loaded
//     frame_error    out  one-cycle strobe on parity, stop or timeout error
//
//   Output strobes: scan_valid and frame_error are single-cycle pulses
//   with no backpressure; a consumer must sample them every cycle. They
//   are mutually exclusive, and keys_keyboard is already updated in the
//   cycle scan_valid is high.
//
//   Internal state_q is the receive FSM state and is the point to observe
//   the receiver from outside.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keys_keyboard,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------------
  // Line conditioning
  // ---------------------------------------------------------------------
  logic clk_fall;
  logic data_bit;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_fall (clk_fall),
    .data_bit (data_bit)
  );

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] idle_cnt_q;

  logic frame_ok;
  logic frame_bad;
  logic timeout_hit;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
    end
  end

  // Next-state logic: every sampled falling edge advances exactly one step.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    if (clk_fall) begin
      case (state_q)
        ST_IDLE: begin
          // A high "start" bit is line noise, not a frame.
          if (!data_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = data_bit;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
    end
  end

  // Output logic: frame verdicts in the cycle the stop bit is sampled.
  // Odd parity means the nine bits {data, parity} XOR to 1.
  always_comb begin
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    timeout_hit = 1'b0;
    if (clk_fall && (state_q == ST_STOP)) begin
      if (data_bit && (^{shift_q, parity_q})) begin
        frame_ok = 1'b1;
      end else begin
        frame_bad = 1'b1;
      end
    end
    // An edge in the same cycle always wins over the timeout.
    if ((state_q != ST_IDLE) && !clk_fall &&
        (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1))) begin
      timeout_hit = 1'b1;
    end
  end

  // Cycles spent mid-frame since the last falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) || clk_fall || timeout_hit) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Byte interpretation: prefix flags and held-key tracking
  // ---------------------------------------------------------------------
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [3:0] keys_d;
  logic [3:0] mask;

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    keys_d = keys_keyboard;
    mask   = key_mask(shift_q);
    if (frame_ok) begin
      if (shift_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == CODE_BREAK) begin
        brk_d = 1'b1;
      end else begin
        // Any other byte closes the prefix sequence. The extended flag
        // does not change the mapping: arrow keys decode the same with
        // or without E0, and unmapped codes leave mask at zero.
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (brk_q) begin
          keys_d = keys_keyboard & ~mask;
        end else begin
          keys_d = keys_keyboard | mask;
        end
      end
    end else if (frame_bad || timeout_hit) begin
      // A lost byte may have been a prefix; drop any partial sequence.
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  // The verdict registers here, so scan_valid, scan_code and
  // keys_keyboard all change in the cycle after the stop sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      keys_keyboard <= 4'b0000;
      scan_code     <= 8'h00;
      scan_valid    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      keys_keyboard <= keys_d;
      scan_valid    <= frame_ok;
      frame_error   <= frame_bad | timeout_hit;
      if (frame_ok) begin
        scan_code <= shift_q;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Drives PS/2 frames into ps2_key_decoder and checks decoded bytes,
//   held-key state and error strobes against a table of hand-computed
//   results and against a key-tracking model.
module tb_ps2_key_decoder;
  import ps2_key_decoder_pkg::*;

  localparam int HALF = 20;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] keys_keyboard;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;

  always #5 clock = ~clock;

  ps2_key_decoder dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .keys_keyboard (keys_keyboard),
    .scan_code     (scan_code),
    .scan_valid    (scan_valid),
    .frame_error   (frame_error)
  );

  // ---------------------------------------------------------------------
  // Counters, scoreboard, model
  // ---------------------------------------------------------------------
  int          n_cmp     = 0;
  int          n_bad     = 0;
  int          valid_cnt = 0;
  int          err_cnt   = 0;
  logic [11:0] exp_q[$];      // {keys_keyboard, scan_code} expected at each scan_valid
  logic [11:0] sb_e;

  logic [3:0]  m_keys = 4'b0000;
  logic        m_ext  = 1'b0;
  logic        m_brk  = 1'b0;
  logic [7:0]  key_codes [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor sampled on the falling clock edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (scan_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_scan: code %0h keys %b with nothing expected", scan_code, keys_keyboard);
        end else begin
          sb_e = exp_q.pop_front();
          check("scan_and_keys", {20'd0, keys_keyboard, scan_code}, {20'd0, sb_e});
        end
      end
      if (frame_error) err_cnt++;
      if (scan_valid && frame_error) begin
        n_cmp++;
        n_bad++;
        $display("FAIL valid_err_same_cycle: both strobes high, required at most one");
      end
    end
  end

  // Reference model: held-key set driven by the byte stream.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      for (int i = 0; i < 4; i++)
        if (key_codes[i] == b) m_keys[i] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      tick(4);
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      tick(3);
    end else begin
      tick(10);
    end
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF / 2);
  endtask

  // kind: 0 clean, 1 parity flipped, 2 stop bit low
  task automatic send_frame(input logic [7:0] b, input int kind, input bit glitch);
    logic p;
    p = ~(^b);
    if (kind == 1) p = ~p;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(p, glitch);
    send_bit((kind == 2) ? 1'b0 : 1'b1, glitch);
    ps2_data = 1'b1;
    tick(30);
  endtask

  // Sends one frame, keeps the model in step and checks strobe counts.
  task automatic do_frame(input logic [7:0] b, input int kind, input bit glitch);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    if (kind == 0) begin
      model_byte(b);
      exp_q.push_back({m_keys, b});
    end else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    send_frame(b, kind, glitch);
    check("valid_pulses", valid_cnt - v0, (kind == 0) ? 1 : 0);
    check("error_pulses", err_cnt - e0, (kind == 0) ? 0 : 1);
    check("keys_vs_model", keys_keyboard, m_keys);
  endtask

  // ---------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------
  typedef struct {
    logic [7:0] code;
    int         kind;
    logic [3:0] keys;
  } vec_t;

  vec_t tbl [18];
  logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hAA, 8'hFA};

  initial begin
    int v0, e0;
    logic [7:0] code;
    int kind;

    tbl[0]  = '{8'h75, 0, 4'b0001};
    tbl[1]  = '{8'hE0, 0, 4'b0001};
    tbl[2]  = '{8'h74, 0, 4'b1001};
    tbl[3]  = '{8'hE0, 0, 4'b1001};
    tbl[4]  = '{8'hF0, 0, 4'b1001};
    tbl[5]  = '{8'h74, 0, 4'b0001};
    tbl[6]  = '{8'h75, 0, 4'b0001};
    tbl[7]  = '{8'h6B, 1, 4'b0001};
    tbl[8]  = '{8'hF0, 0, 4'b0001};
    tbl[9]  = '{8'h72, 0, 4'b0001};
    tbl[10] = '{8'hAA, 0, 4'b0001};
    tbl[11] = '{8'hFA, 0, 4'b0001};
    tbl[12] = '{8'hF0, 0, 4'b0001};
    tbl[13] = '{8'h6B, 2, 4'b0001};
    tbl[14] = '{8'h6B, 0, 4'b0101};
    tbl[15] = '{8'hF0, 0, 4'b0101};
    tbl[16] = '{8'h75, 0, 4'b0100};
    tbl[17] = '{8'h72, 0, 4'b0110};

    // Reset state
    tick(5);
    check("rst_keys", keys_keyboard, 4'b0000);
    check("rst_scan_code", scan_code, 8'h00);
    check("rst_scan_valid", scan_valid, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset_n = 1'b1;
    tick(20);

    // Table
    for (int i = 0; i < 18; i++) begin
      do_frame(tbl[i].code, tbl[i].kind, 1'b0);
      check("tbl_keys", keys_keyboard, tbl[i].keys);
      if (tbl[i].kind == 0) check("tbl_scan_code", scan_code, tbl[i].code);
    end

    // Randomized frames against the model
    for (int i = 0; i < 24; i++) begin
      code = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
      kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_frame(code, kind, 1'b0);
    end

    // Glitches between every edge of a 0x74 frame
    do_frame(8'h74, 0, 1'b1);
    check("glitch_bit3", keys_keyboard[3], 1'b1);
    check("glitch_scan_code", scan_code, 8'h74);

    // Partial frame then silence
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    v0 = valid_cnt;
    e0 = err_cnt;
    tick(49900);
    check("timeout_not_early", err_cnt - e0, 0);
    tick(200);
    check("timeout_error_once", err_cnt - e0, 1);
    check("timeout_no_valid", valid_cnt - v0, 0);
    check("timeout_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    m_ext = 1'b0;
    m_brk = 1'b0;
    do_frame(8'h72, 0, 1'b0);
    check("after_timeout_bit1", keys_keyboard[1], 1'b1);

    // Reset in the middle of a frame with a key held
    do_frame(8'h75, 0, 1'b0);
    check("held_bit0", keys_keyboard[0], 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_keys", keys_keyboard, 4'b0000);
    check("midrst_scan_code", scan_code, 8'h00);
    check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    tick(2);
    reset_n = 1'b1;
    m_keys = 4'b0000;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    e0 = err_cnt;
    v0 = valid_cnt;
    tick(200);
    check("midrst_no_error", err_cnt - e0, 0);
    check("midrst_no_valid", valid_cnt - v0, 0);
    do_frame(8'h75, 0, 1'b0);
    check("post_rst_keys", keys_keyboard, 4'b0001);
    check("post_rst_scan_code", scan_code, 8'h75);

    tick(10);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
